// File: rtl/itcm_port_arbiter.sv
// Arbiter for the ITCM read/write port. The LSU has priority. A starvation counter
// guarantees the program loader progress, and the loader can lock the port for bursts.
module itcm_port_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_req,
  input  logic              lsu_we,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  output logic              lsu_gnt,
  output logic              lsu_rvalid,
  output logic [DATA_W-1:0] lsu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic              ldr_lock,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              core_hold
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic {ARB = 1'b0, LDR_LOCK = 1'b1} state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             rd_pending;
  logic             rd_owner;   // 1: loader, 0: LSU

  // Grants are suppressed while reset is asserted so that no transfer starts
  always_comb begin
    ldr_gnt = 1'b0;
    lsu_gnt = 1'b0;
    if (!rst) begin
      if (state == LDR_LOCK) begin
        ldr_gnt = ldr_req;
      end else begin
        ldr_gnt = ldr_req & ((starve_cnt == CNT_MAX) | ~lsu_req);
        lsu_gnt = lsu_req & ~ldr_gnt;
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ldr_gnt) begin
      mem_we    = ldr_we;
      mem_addr  = ldr_addr;
      mem_wdata = ldr_wdata;
    end else if (lsu_gnt) begin
      mem_we    = lsu_we;
      mem_addr  = lsu_addr;
      mem_wdata = lsu_wdata;
    end
  end

  assign lsu_rvalid = rd_pending & ~rd_owner;
  assign ldr_rvalid = rd_pending & rd_owner;
  assign lsu_rdata  = lsu_rvalid ? mem_rdata : '0;
  assign ldr_rdata  = ldr_rvalid ? mem_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB;
      core_hold  <= 1'b0;
      starve_cnt <= '0;
      rd_pending <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      case (state)
        ARB: begin
          if (ldr_gnt && ldr_lock) begin
            state     <= LDR_LOCK;
            core_hold <= 1'b1;
          end else begin
            core_hold <= 1'b0;
          end
        end
        LDR_LOCK: begin
          // The exit cycle still grants the loader; core_hold drops with the state
          if (!ldr_lock) begin
            state     <= ARB;
            core_hold <= 1'b0;
          end else begin
            core_hold <= 1'b1;
          end
        end
        default: begin
          state     <= ARB;
          core_hold <= 1'b0;
        end
      endcase

      if (ldr_req && !ldr_gnt) begin
        if (starve_cnt != CNT_MAX) starve_cnt <= starve_cnt + CNT_W'(1);
      end else begin
        starve_cnt <= '0;
      end

      rd_pending <= (lsu_gnt & ~lsu_we) | (ldr_gnt & ~ldr_we);
      rd_owner   <= ldr_gnt;
    end
  end

endmodule
